// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle in round-robin
// order and holds it in a single output register stage broadcast to the ROB/RS/RAT.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROB_W   = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_exc,
  output logic                      cdb_valid,
  input  logic                      cdb_ready,
  output logic [ROB_W-1:0]          cdb_rob_idx,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_exc,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  logic              cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]  cdb_rob_idx_q, cdb_rob_idx_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_exc_q, cdb_exc_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic [SRC_W-1:0]  prio_q, prio_d;

  logic [SRC_W-1:0]  scan_idx;
  logic [SRC_W-1:0]  win;
  logic              found;
  logic              can_load;
  logic              xfer;

  assign can_load = !cdb_valid_q || cdb_ready;

  // Round-robin search starting at prio; the wrap is an explicit compare so that
  // non-power-of-two unit counts never index past the last requester.
  // NOTE: every variable driven here gets a default before any conditional logic,
  // otherwise synthesis infers a latch to hold its old value.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = prio_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
  end

  assign xfer      = found && can_load && !flush && !rst;
  assign req_ready = xfer ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_rob_idx_d = cdb_rob_idx_q;
    cdb_data_d    = cdb_data_q;
    cdb_exc_d     = cdb_exc_q;
    cdb_src_d     = cdb_src_q;
    prio_d        = prio_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (xfer) begin
      cdb_valid_d   = 1'b1;
      cdb_rob_idx_d = req_rob_idx[int'(win)*ROB_W +: ROB_W];
      cdb_data_d    = req_data[int'(win)*DATA_W +: DATA_W];
      cdb_exc_d     = req_exc[win];
      cdb_src_d     = win;
      prio_d        = (win == LAST_IDX) ? '0 : win + 1'b1;
    end else if (cdb_ready) begin
      cdb_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_data_q    <= '0;
      cdb_exc_q     <= 1'b0;
      cdb_src_q     <= '0;
      prio_q        <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_data_q    <= cdb_data_d;
      cdb_exc_q     <= cdb_exc_d;
      cdb_src_q     <= cdb_src_d;
      prio_q        <= prio_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_exc     = cdb_exc_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference round-robin model predicts each grant,
// pushes the expected broadcast and compares it when the bus updates.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  src;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [3:0]       v;
  logic [3:0]       req_ready;
  logic [3:0][3:0]  rob_a;
  logic [3:0][31:0] dat_a;
  logic [3:0]       exc_a;
  logic             cdb_valid;
  logic             cdb_ready;
  logic [3:0]       cdb_rob_idx;
  logic [31:0]      cdb_data;
  logic             cdb_exc;
  logic [1:0]       cdb_src;

  exp_t sb_q[$];
  exp_t m_out;
  bit   m_valid;
  int   m_prio;
  bit   refresh;
  int   n_checks;
  int   n_errors;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (v),
    .req_ready   (req_ready),
    .req_rob_idx (rob_a),
    .req_data    (dat_a),
    .req_exc     (exc_a),
    .cdb_valid   (cdb_valid),
    .cdb_ready   (cdb_ready),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data),
    .cdb_exc     (cdb_exc),
    .cdb_src     (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: predict and check req_ready, then check the bus after the edge.
  task automatic step();
    int   w;
    bit   xfer;
    bit   can_load;
    bit   was_rst;
    bit   was_flush;
    bit   was_ready;
    logic [3:0] exp_rdy;
    #1;
    can_load = !m_valid || cdb_ready;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_prio + k) % 4;
      if (w < 0 && v[idx]) w = idx;
    end
    exp_rdy = '0;
    xfer    = 1'b0;
    if (w >= 0 && can_load && !flush && !rst) begin
      exp_rdy[w] = 1'b1;
      xfer       = 1'b1;
      sb_q.push_back('{rob: rob_a[w], data: dat_a[w], exc: exc_a[w], src: 2'(w)});
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    was_rst   = rst;
    was_flush = flush;
    was_ready = cdb_ready;
    @(posedge clk);
    #1;
    if (was_rst) begin
      m_valid = 1'b0;
      m_prio  = 0;
      m_out   = '0;
    end else if (was_flush) begin
      m_valid = 1'b0;
    end else if (xfer) begin
      m_out   = sb_q.pop_front();
      m_valid = 1'b1;
      m_prio  = (w + 1) % 4;
    end else if (was_ready) begin
      m_valid = 1'b0;
    end
    check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    if (was_rst || m_valid) begin
      check("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_out.rob));
      check("cdb_data", 64'(cdb_data), 64'(m_out.data));
      check("cdb_exc", 64'(cdb_exc), 64'(m_out.exc));
      check("cdb_src", 64'(cdb_src), 64'(m_out.src));
    end
    if (xfer) begin
      if (refresh) dat_a[w] = dat_a[w] + 32'h0101_0101;
      else         v[w] = 1'b0;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_valid   = 1'b0;
    m_prio    = 0;
    m_out     = '0;
    refresh   = 1'b1;
    rst       = 1'b1;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    v         = 4'b1111;
    exc_a     = '0;
    for (int i = 0; i < 4; i++) begin
      rob_a[i] = 4'(i + 1);
      dat_a[i] = 32'h1000 + 32'(i);
    end

    // Reset with all units requesting, then round-robin with immediate re-presentation
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Skip/wrap: move prio to 2 via unit 1, then units 1 and 3 compete
    refresh = 1'b0;
    v = 4'b0010;
    step();
    rob_a[1] = 4'd5;
    dat_a[1] = 32'hDEAD_BEEF;
    v = 4'b1010;
    step();
    step();
    step();

    // Back-pressure: rob_idx 7 on the bus, unit 2 waiting
    rob_a[0] = 4'd7;
    dat_a[0] = 32'h0000_0777;
    v = 4'b0001;
    step();
    cdb_ready = 1'b0;
    rob_a[2]  = 4'd9;
    dat_a[2]  = 32'h0000_0999;
    v = 4'b0100;
    for (int i = 0; i < 3; i++) step();
    cdb_ready = 1'b1;
    step();

    // Flush while valid and unit 2 requesting; the next winner proves prio was kept
    rob_a[0] = 4'd4;
    dat_a[0] = 32'hAAAA_0000;
    rob_a[2] = 4'd10;
    dat_a[2] = 32'hBBBB_0000;
    v = 4'b0101;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();

    // Exception from the LSU
    rob_a[2] = 4'd3;
    dat_a[2] = 32'h0BAD_F00D;
    exc_a[2] = 1'b1;
    v = 4'b0100;
    step();
    exc_a[2] = 1'b0;
    step();

    // Reset mid-operation overrides flush and pending transfers
    v = 4'b1111;
    step();
    rst   = 1'b1;
    flush = 1'b1;
    step();
    rst   = 1'b0;
    flush = 1'b0;
    step();
    v = 4'b0000;
    step();
    step();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) among the execution units: ALU, MUL, LSU and BRU.
- Each cycle at most one completed result (ROB index, data, exception flag) is granted. The grant uses round-robin priority.
- The granted result is registered and broadcast to the ROB, the reservation stations and the RAT-forwarding path.
- The block sits between the execute-stage writeback ports and the ROB completion port. It is flushed together with the RAT on rollback.

Parameters:
- NUM_REQ, 4, number of requesting execution units (index 0=ALU, 1=MUL, 2=LSU, 3=BRU).
- ROB_W, 4, ROB index width; equals `ROB_ENTRY_WIDTH.
- DATA_W, 32, result data width.
- SRC_W, 2, width of the source-unit ID; equals clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  rollback/mispredict flush; same cycle as the RAT rollback.
- req_valid  input  NUM_REQ  per-unit result-valid flag.
- req_ready  output  NUM_REQ  per-unit accept; combinational.
- req_rob_idx  input  NUM_REQ*ROB_W  packed ROB indices; unit i occupies bits [i*ROB_W +: ROB_W].
- req_data  input  NUM_REQ*DATA_W  packed result data.
- req_exc  input  NUM_REQ  per-unit exception flag.
- cdb_valid  output  1  broadcast valid.
- cdb_ready  input  1  ROB can accept a completion this cycle.
- cdb_rob_idx  output  ROB_W  broadcast ROB index.
- cdb_data  output  DATA_W  broadcast data.
- cdb_exc  output  1  broadcast exception flag.
- cdb_src  output  SRC_W  ID of the unit that produced the broadcast.

Behaviour:
- Handshakes:
  - Requester side: unit i transfers when req_valid[i] && req_ready[i].
  - Once req_valid[i] is high, the unit holds req_valid, req_rob_idx, req_data and req_exc stable until the transfer occurs.
  - Output side: a broadcast is consumed when cdb_valid && cdb_ready.
- Output register:
  - A single register stage holds cdb_* outputs.
  - can_load = !cdb_valid || cdb_ready.
- Arbitration (combinational):
  - Internal pointer prio (SRC_W bits).
  - Search order: prio, prio+1, ..., wrapping modulo NUM_REQ.
  - The first index with req_valid set wins.
  - req_ready[win] = can_load && !flush && !rst. All other bits of req_ready are 0.
  - req_ready is never high for an index whose req_valid is low.
- Latency:
  - A request accepted in cycle T appears on cdb_* in cycle T+1.
  - Full throughput: one broadcast per cycle while cdb_ready stays high.
- Pointer update:
  - On a transfer from unit w: prio <= (w+1) mod NUM_REQ.
  - With no transfer: prio is unchanged.
  - Fairness guarantee: a continuously requesting unit is granted within NUM_REQ transfers.
- Register update, in priority order:
  1. rst: cdb_valid=0, cdb_rob_idx=0, cdb_data=0, cdb_exc=0, cdb_src=0, prio=0.
  2. flush: cdb_valid<=0. No grant in this cycle. prio is unchanged. Data fields may be left stale. Any pending request is dropped by its owner, not by this block.
  3. Transfer: load the winner's fields into cdb_*, set cdb_valid<=1, set cdb_src<=w.
  4. cdb_ready && no transfer: cdb_valid<=0.
  5. Otherwise (stall): hold all cdb_* fields.
- Stall: while cdb_valid && !cdb_ready, all req_ready are 0 and the output fields are held bit-stable.
- Simultaneous consume and load: when cdb_ready=1 and a new transfer occurs in the same cycle, the new result replaces the old one with no bubble.
- Reset mid-operation: rst overrides flush and any transfer. req_ready is forced to 0 in the rst cycle.
- Widths:
  - Pointer wrap-around uses an explicit compare to NUM_REQ-1, so it is correct for non-power-of-2 NUM_REQ.
  - cdb_src is zero-extended from the loop index.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with all req_valid=4'b1111.
  - Required: req_ready=0 and cdb_valid=0 during reset.
  - Required: first cycle after release, req_ready=4'b0001; next cycle cdb_src=0 with ALU's rob_idx/data on the bus.
- Round-robin fairness:
  - Stimulus: req_valid=4'b1111 held with cdb_ready=1, each unit re-presenting immediately with a new data value after its transfer.
  - Required: grants ordered 0,1,2,3,0,...; cdb_valid continuously high; cdb_src sequence 0,1,2,3,0.
- Skip/wrap:
  - Stimulus: only units 1 and 3 request, prio=2.
  - Required: unit 3 granted first, then unit 1. Unit 1 broadcast carries its data, e.g. rob_idx=5, data=0xDEADBEEF.
- Back-pressure:
  - Stimulus: hold cdb_ready=0 for 3 cycles while the bus holds rob_idx=7.
  - Required: req_ready=0 throughout; cdb_* fields bit-stable.
  - Stimulus: raise cdb_ready.
  - Required: next winner loads in the same cycle as the consume.
- Flush:
  - Stimulus: flush while cdb_valid=1 and unit 2 is requesting.
  - Required: req_ready=0 in the flush cycle; cdb_valid=0 next cycle; prio unchanged.
- Exception propagation:
  - Stimulus: unit 2 (LSU) presents req_exc=1, rob_idx=3.
  - Required: cdb_exc=1, cdb_rob_idx=3, cdb_src=2 one cycle later.
